// File: rtl/ram_io_responder.sv
// CPU byte-bus responder: 128 KB RAM, UART TX FIFO, RX holding byte and a free-running cycle counter.
// Define RESP_CYCLE_SNAPSHOT_EN to make counter dword reads coherent through a snapshot taken at 0x30004.
module ram_io_responder #(
  parameter int RAM_ADDR_W  = 17,
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_wr,
  output logic [7:0]  cpu_din,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // ---------------------------------------------------------------- decode
  logic io_sel;
  logic io_data_sel;
  logic io_cnt_sel;
  logic io_stop_sel;
  logic rd_en;
  logic ram_rd;
  logic ram_wr;

  assign io_sel      = (cpu_a[17:16] == 2'b11);
  assign io_data_sel = io_sel && (cpu_a[15:0] == 16'h0000);
  assign io_stop_sel = io_sel && (cpu_a[15:0] == 16'h0004);
  assign io_cnt_sel  = io_sel && (cpu_a[15:2] == 14'h0001);
  assign rd_en       = !cpu_wr;
  assign ram_rd      = rd_en && !io_sel;
  assign ram_wr      = cpu_wr && !io_sel;

  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, cpu_a[31:18]};

  // ---------------------------------------------------------------- RAM
  logic [RAM_ADDR_W-1:0] ram_addr;
  logic [7:0]            mem [0:(1 << RAM_ADDR_W) - 1];
  logic [7:0]            ram_rd_q;

  assign ram_addr = cpu_a[RAM_ADDR_W-1:0];

  // Read-enabled port so the output register holds across write cycles.
  always_ff @(posedge clk_in) begin
    if (ram_wr) begin
      mem[ram_addr] <= cpu_dout;
    end
    if (ram_rd) begin
      ram_rd_q <= mem[ram_addr];
    end
  end

  // ---------------------------------------------------------------- cycle counter
  logic [31:0] cnt_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  logic [31:0] cnt_src;

`ifdef RESP_CYCLE_SNAPSHOT_EN
  logic [31:0] snap_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      snap_q <= '0;
    end else if (rd_en && io_cnt_sel && (cpu_a[1:0] == 2'b00)) begin
      snap_q <= cnt_q;
    end
  end

  // Byte 0 comes from the live counter; the rest from the copy taken with it.
  assign cnt_src = (cpu_a[1:0] == 2'b00) ? cnt_q : snap_q;
`else
  assign cnt_src = cnt_q;
`endif

  logic [7:0] cnt_bytes [4];
  logic [7:0] cnt_byte;

  for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_byte
    assign cnt_bytes[gi] = cnt_src[8*gi +: 8];
  end

  assign cnt_byte = cnt_bytes[cpu_a[1:0]];

  // ---------------------------------------------------------------- RX holding byte
  logic       rx_full_q;
  logic [7:0] rx_byte_q;
  logic       rx_accept;
  logic       rx_take;

  assign rx_accept = rx_valid && !rx_full_q;
  assign rx_take   = rd_en && io_data_sel;
  assign rx_ready  = !rx_full_q;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_full_q <= 1'b0;
      rx_byte_q <= 8'h00;
    end else if (rx_accept) begin
      rx_full_q <= 1'b1;
      rx_byte_q <= rx_data;
    end else if (rx_take) begin
      rx_full_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------- read data path
  logic [7:0] io_rd_d;
  logic [7:0] io_rd_q;
  logic       sel_ram_q;

  always_comb begin
    io_rd_d = 8'h00;
    if (io_data_sel) begin
      io_rd_d = rx_full_q ? rx_byte_q : 8'h00;
    end else if (io_cnt_sel) begin
      io_rd_d = cnt_byte;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      io_rd_q   <= 8'h00;
      sel_ram_q <= 1'b0;
    end else if (rd_en) begin
      sel_ram_q <= !io_sel;
      if (io_sel) begin
        io_rd_q <= io_rd_d;
      end
    end
  end

  assign cpu_din = sel_ram_q ? ram_rd_q : io_rd_q;

  // ---------------------------------------------------------------- TX FIFO
  logic [7:0]       fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             stop_q;
  logic             ovf_q;
  logic             full_q;
  logic             full_d;
  logic             push_req;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic [7:0]       push_byte;

  assign push_req  = cpu_wr && !stop_q && ((io_data_sel && (cpu_dout != 8'h00)) || io_stop_sel);
  assign push_byte = io_data_sel ? cpu_dout : 8'h00;
  assign fifo_full = (count_q == CNT_W'(TX_DEPTH));
  assign pop       = (count_q != '0) && tx_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push      = push_req && (!fifo_full || pop);

  always_comb begin
    count_d = count_q + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
    full_d  = ((CNT_W'(TX_DEPTH) - count_d) <= CNT_W'(FULL_MARGIN));
  end

  always_ff @(posedge clk_in) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= push_byte;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      stop_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
      full_q  <= full_d;
      if (cpu_wr && io_stop_sel) begin
        stop_q <= 1'b1;
      end
      if (push_req && !push) begin
        ovf_q <= 1'b1;
      end
    end
  end

  assign tx_valid       = (count_q != '0);
  assign tx_data        = fifo_mem[rd_ptr_q];
  assign io_buffer_full = full_q;
  assign program_stop   = stop_q;
  assign tx_overflow    = ovf_q;

endmodule
